ro_aging_monitor: RTL and testbench
===================================

# ro_aging_monitor

Multi-channel controller and frequency counter for an array of `N_RO` ring oscillators used as BTI/aging sensors. For each oscillator it drives the `Mode` (oscillate enable) and `Stress` controls. On request it takes one selected oscillator out of stress, lets it oscillate, and counts its rising edges over a programmable window of `CLK` cycles. All other oscillators stay under the global stress setting, so the array can age while individual channels are sampled.

## Interface
Parameters:
- `N_RO`, 4: number of ring oscillators (1..256).
- `CNT_W`, 16: width of the edge counter and `COUNT`.
- `WIN_W`, 16: width of `WINDOW`.
- `SETTLE_CYC`, 4: cycles between enabling the oscillator and opening the count window (≥3).

Ports (`SEL_W = max(1, ceil(log2(N_RO)))`):
- `CLK`  in  1  system clock; single clock domain.
- `RST_N`  in  1  reset, synchronous, active-low.
- `START`  in  1  measurement request, sampled in IDLE only.
- `CH_SEL`  in  SEL_W  channel to measure, captured with `START`.
- `WINDOW`  in  WIN_W  count window in `CLK` cycles, captured with `START`.
- `STRESS_EN`  in  1  global stress request for non-measured channels.
- `RO_IN`  in  N_RO  raw oscillator outputs; asynchronous, each passes through a 2-flop synchronizer.
- `MODE`  out  N_RO  per-channel oscillate enable (1 = ring closed).
- `STRESS`  out  N_RO  per-channel stress control.
- `BUSY`  out  1  high from the cycle after an accepted `START` through the `DONE` cycle.
- `DONE`  out  1  one-cycle pulse when `COUNT` is valid.
- `COUNT`  out  CNT_W  edge count of the last measurement; held until the next `DONE`.
- `OVF`  out  1  the last measurement saturated; updated with `COUNT`.

## Operation
- Edge detect: a third register follows the synchronizer on every channel. `rise[i]` = sync[i] & ~prev[i].
- FSM states: IDLE → SETTLE → MEASURE → FINISH → IDLE.
- **IDLE**
  - `MODE` = 0.
  - `STRESS` = {N_RO{STRESS_EN}}, registered.
  - `BUSY` = 0.
  - `START`=1 with `CH_SEL` < `N_RO` captures `CH_SEL` and `WINDOW`, clears the counter and OVF flag, and moves to SETTLE.
  - `START` with out-of-range `CH_SEL` is ignored: no state change, no `DONE`.
- **SETTLE**
  - `MODE[sel]`=1 and `STRESS[sel]`=0; all other channels follow IDLE rules.
  - Lasts exactly `SETTLE_CYC` cycles, then moves to MEASURE.
  - If the captured `WINDOW`=0, SETTLE goes directly to FINISH with `COUNT`=0.
- **MEASURE**
  - Lasts exactly `WINDOW` cycles.
  - Each cycle with `rise[sel]`=1 increments the counter.
  - The counter saturates at 2^CNT_W−1; an increment attempted at saturation sets the internal OVF flag.
- **FINISH** (one cycle)
  - `COUNT` and `OVF` load from the counter and flag.
  - `DONE`=1.
  - `MODE[sel]` returns to 0.
  - Next state is IDLE.
- `START` while `BUSY`=1 is ignored; it is not queued.
- `STRESS_EN` changes take effect on non-selected channels at all times, with 1-cycle latency. The selected channel ignores `STRESS_EN` from SETTLE through FINISH.
- Reset (`RST_N`=0 at a `CLK` edge), including mid-measurement: FSM to IDLE, `MODE`=0, `STRESS`=0, `BUSY`=0, `DONE`=0, `COUNT`=0, `OVF`=0, synchronizers cleared. An aborted measurement produces no `DONE`.

## Timing
- All outputs are registered.
- `START` accepted at edge t0:
  - `BUSY`, `MODE[sel]` and `STRESS[sel]`=0 are visible after t0+1.
  - MEASURE covers cycles t0+1+SETTLE_CYC … t0+SETTLE_CYC+WINDOW.
  - `DONE` is high for the cycle following edge t0+1+SETTLE_CYC+WINDOW.
- Total latency from accepted `START` to `DONE` is `SETTLE_CYC+WINDOW+1` cycles (`SETTLE_CYC+1` when `WINDOW`=0).
- `RO_IN`-to-`rise` latency is 3 cycles. `SETTLE_CYC`≥3 guarantees no edge from before enable is counted.
- Counting is exact for oscillator periods ≥ 2 `CLK` cycles (per-cycle high and low each ≥ 1 cycle). Faster oscillators alias; the block has no divider.
- A new `START` is accepted in the first IDLE cycle after `DONE`.

## Test plan
- Reset: hold `RST_N`=0 for 3 cycles with `STRESS_EN`=1 → all outputs 0. After release, `STRESS`=4'b1111 within 1 cycle and `MODE`=0.
- Nominal measurement: N_RO=4, `STRESS_EN`=1, `CH_SEL`=2, `WINDOW`=100, `RO_IN[2]` toggling every 2 cycles (period 4) → `MODE`=4'b0100 and `STRESS`=4'b1011 during measurement. `DONE` arrives 105 cycles after `START` with `COUNT`=25, `OVF`=0. Afterwards `MODE`=0 and `STRESS`=4'b1111.
- Saturation: CNT_W=4, `WINDOW`=100, period 4 → `COUNT`=15, `OVF`=1. A following run with `WINDOW`=20 gives `COUNT`=5, `OVF`=0.
- Ignored requests:
  - `CH_SEL`=4 → no `BUSY`, no `DONE`.
  - Second `START` pulsed mid-MEASURE → exactly one `DONE`.
  - `WINDOW`=0 → `DONE` 5 cycles after `START` with `COUNT`=0.
- Reset mid-MEASURE: assert `RST_N`=0 at cycle 50 of a 100-cycle window → no `DONE`, `COUNT`=0. A fresh measurement afterwards matches the nominal result.
- Stress toggle during a measurement of channel 0: `STRESS_EN` 1→0 → `STRESS[3:1]` goes to 0 one cycle later while `STRESS[0]` stays 0, and `COUNT` is unaffected.

Source files
------------

// File: rtl/ro_aging_monitor.sv
// ro_aging_monitor
// Controller and frequency counter for an array of ring-oscillator aging
// sensors. Every channel sits under the global stress setting. On request,
// one channel is released from stress and its ring is closed. After a
// settle period, its rising edges are counted over a programmable window.
//
// Ports
//   clk        system clock
//   rst_n      synchronous active-low reset
//   start      measurement request (taken only when idle and not busy)
//   ch_sel     channel to measure, captured with start
//   window     count window in clk cycles, captured with start
//   stress_en  global stress request for channels not being measured
//   ro_in      raw asynchronous oscillator outputs
//   mode       per-channel oscillate enable (1 = ring closed)
//   stress     per-channel stress control
//   busy       high from the cycle after an accepted start through done
//   done       one-cycle pulse when count/ovf are valid
//   count      edge count of the last measurement, held until next done
//   ovf        last measurement saturated the counter
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | no channel selected; waits for a valid start
// S_SETTLE  | ring closed, edges not yet counted (SETTLE_CYC cycles)
// S_MEASURE | count rising edges of the selected channel (window cycles)
// S_FINISH  | publish count/ovf, pulse done, release the channel
module ro_aging_monitor #(
  parameter int N_RO       = 4,
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 16,
  parameter int SETTLE_CYC = 4,
  localparam int SEL_W     = (N_RO > 1) ? $clog2(N_RO) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SEL_W-1:0] ch_sel,
  input  logic [WIN_W-1:0] window,
  input  logic             stress_en,
  input  logic [N_RO-1:0]  ro_in,
  output logic [N_RO-1:0]  mode,
  output logic [N_RO-1:0]  stress,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  localparam int ST_W = $clog2(SETTLE_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_MEASURE, S_FINISH} state_t;

  state_t           state;
  logic [N_RO-1:0]  ro_s1, ro_s2, ro_prev;
  logic [N_RO-1:0]  rise;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] tgt;
  logic [WIN_W-1:0] win_tmr;
  logic [ST_W-1:0]  set_tmr;
  logic [CNT_W-1:0] cnt;
  logic             ovf_q;
  logic             accept;
  logic             hold;

  assign rise = ro_s2 & ~ro_prev;

  // busy is still high in the done cycle, so a start there is dropped
  assign accept = (state == S_IDLE) && start && !busy &&
                  ({1'b0, ch_sel} < (SEL_W + 1)'(N_RO));

  // The channel stays owned from acceptance through the FINISH cycle
  // because the outputs are registered one cycle ahead.
  assign hold = accept || (state == S_SETTLE) || (state == S_MEASURE);
  assign tgt  = accept ? ch_sel : sel_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      ro_s1   <= '0;
      ro_s2   <= '0;
      ro_prev <= '0;
      sel_q   <= '0;
      win_tmr <= '0;
      set_tmr <= '0;
      cnt     <= '0;
      ovf_q   <= 1'b0;
      mode    <= '0;
      stress  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      count   <= '0;
      ovf     <= 1'b0;
    end else begin
      ro_s1   <= ro_in;
      ro_s2   <= ro_s1;
      ro_prev <= ro_s2;
      done    <= 1'b0;

      for (int i = 0; i < N_RO; i++) begin
        mode[i]   <= hold && (SEL_W'(i) == tgt);
        stress[i] <= stress_en && !(hold && (SEL_W'(i) == tgt));
      end

      case (state)
        S_IDLE: begin
          busy <= 1'b0;
          if (accept) begin
            state   <= S_SETTLE;
            sel_q   <= ch_sel;
            win_tmr <= window;
            set_tmr <= ST_W'(SETTLE_CYC - 1);
            cnt     <= '0;
            ovf_q   <= 1'b0;
            busy    <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (set_tmr == '0) begin
            if (win_tmr == '0) begin
              state <= S_FINISH;
            end else begin
              state   <= S_MEASURE;
              win_tmr <= win_tmr - WIN_W'(1);
            end
          end else begin
            set_tmr <= set_tmr - ST_W'(1);
          end
        end
        S_MEASURE: begin
          if (rise[sel_q]) begin
            if (&cnt) ovf_q <= 1'b1;
            else      cnt   <= cnt + CNT_W'(1);
          end
          if (win_tmr == '0) state <= S_FINISH;
          else               win_tmr <= win_tmr - WIN_W'(1);
        end
        S_FINISH: begin
          count <= cnt;
          ovf   <= ovf_q;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_aging_monitor.sv
module tb_ro_aging_monitor;

  localparam int S = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, start3, stress_en;
  logic [1:0]  ch_sel;
  logic [15:0] window;
  logic [3:0]  ro_in;

  logic [3:0]  mode, stress, mode4, stress4;
  logic [2:0]  mode3, stress3;
  logic        busy, done, ovf, busy4, done4, ovf4, busy3, done3, ovf3;
  logic [15:0] count, count3;
  logic [3:0]  count4;

  ro_aging_monitor #(.N_RO(4), .CNT_W(16), .WIN_W(16), .SETTLE_CYC(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ch_sel(ch_sel), .window(window),
    .stress_en(stress_en), .ro_in(ro_in), .mode(mode), .stress(stress),
    .busy(busy), .done(done), .count(count), .ovf(ovf));

  ro_aging_monitor #(.N_RO(4), .CNT_W(4), .WIN_W(16), .SETTLE_CYC(S)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .ch_sel(ch_sel), .window(window),
    .stress_en(stress_en), .ro_in(ro_in), .mode(mode4), .stress(stress4),
    .busy(busy4), .done(done4), .count(count4), .ovf(ovf4));

  ro_aging_monitor #(.N_RO(3), .CNT_W(16), .WIN_W(16), .SETTLE_CYC(S)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .ch_sel(ch_sel), .window(window),
    .stress_en(stress_en), .ro_in(ro_in[2:0]), .mode(mode3), .stress(stress3),
    .busy(busy3), .done(done3), .count(count3), .ovf(ovf3));

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int n_done3 = 0;

  always @(negedge clk) begin
    if (done)  n_done++;
    if (done3) n_done3++;
  end

  // waveform of the measured channel; v[k+1] is driven after edge t0+k
  bit v [0:511];

  typedef struct {
    int sel;
    int win;
    int per;
    int exp_cnt;
    int exp_cnt4;
    int exp_ovf4;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One full measurement with per-cycle output checks against the
  // reference timeline. sen_mode: 0 hold stress_en, 1 random per cycle,
  // 2 flip once mid-window.
  task automatic run(input int sel, input int win, input int per,
                     input int sen_mode, input bit midstart);
    int kmax, ph, exp_e, done_k, done_k4, d0;
    bit mode_ok, stress_ok, busy_ok, sen_edge;
    logic [3:0] em, es;
    kmax = S + win + 4;
    ph = (per > 0) ? $urandom_range(per - 1) : 0;
    for (int j = 0; j <= kmax + 1; j++)
      v[j] = (per > 0) ? bit'(((j + ph) / (per / 2)) % 2) : bit'($urandom_range(1));
    // an input rise at step k shows up as a counted edge 3 cycles later
    exp_e = 0;
    for (int k = S - 2; k <= S + win - 3; k++)
      if (v[k + 1] && !v[k]) exp_e++;
    done_k = -1; done_k4 = -1;
    mode_ok = 1; stress_ok = 1; busy_ok = 1;

    @(posedge clk); #1;
    start  = 1'b1;
    ch_sel = 2'(sel);
    window = 16'(win);
    ro_in  = 4'($urandom);
    ro_in[sel] = v[0];
    d0 = n_done;
    for (int k = 0; k <= kmax; k++) begin
      @(posedge clk); #1;
      sen_edge = stress_en;
      start = 1'b0;
      if (midstart && k == S + win / 2) begin
        start  = 1'b1;
        ch_sel = 2'(sel ^ 1);
      end
      em = (k <= S + win) ? (4'b0001 << sel) : 4'b0000;
      es = {4{sen_edge}};
      if (k <= S + win) es[sel] = 1'b0;
      if (mode !== em || mode4 !== em) mode_ok = 0;
      if (stress !== es || stress4 !== es) stress_ok = 0;
      if (busy !== (k <= S + win + 1)) busy_ok = 0;
      if (done === 1'b1 && done_k < 0) done_k = k;
      if (done4 === 1'b1 && done_k4 < 0) done_k4 = k;
      ro_in = 4'($urandom);
      ro_in[sel] = v[k + 1];
      if (sen_mode == 1) stress_en = 1'($urandom_range(1));
      if (sen_mode == 2 && k == S + win / 2) stress_en = ~stress_en;
    end
    start = 1'b0;
    chk("mode_timeline", int'(mode_ok), 1);
    chk("stress_timeline", int'(stress_ok), 1);
    chk("busy_timeline", int'(busy_ok), 1);
    chk("done_latency", done_k, S + win + 1);
    chk("done_latency4", done_k4, S + win + 1);
    chk("done_pulses", n_done - d0, 1);
    chk("count", int'(count), exp_e);
    chk("ovf", int'(ovf), 0);
    chk("count4", int'(count4), (exp_e > 15) ? 15 : exp_e);
    chk("ovf4", int'(ovf4), int'(exp_e > 15));
  endtask

  initial begin
    int d, seen;
    rst_n = 1'b0; start = 1'b0; start3 = 1'b0; stress_en = 1'b1;
    ch_sel = '0; window = '0; ro_in = '0;

    tbl[0] = '{2, 100, 4, 25, 15, 1};
    tbl[1] = '{2, 20, 4, 5, 5, 0};
    tbl[2] = '{0, 0, 4, 0, 0, 0};
    tbl[3] = '{1, 12, 4, 3, 3, 0};
    tbl[4] = '{3, 8, 2, 4, 4, 0};
    tbl[5] = '{0, 16, 8, 2, 2, 0};

    // reset with stress requested
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mode", int'(mode), 0);
    chk("rst_stress", int'(stress), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_ovf", int'(ovf), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_stress", int'(stress), 15);
    chk("post_rst_mode", int'(mode), 0);

    // table-driven measurements
    for (int i = 0; i < 6; i++) begin
      run(tbl[i].sel, tbl[i].win, tbl[i].per, 0, 1'b0);
      chk("tbl_count", int'(count), tbl[i].exp_cnt);
      chk("tbl_count4", int'(count4), tbl[i].exp_cnt4);
      chk("tbl_ovf4", int'(ovf4), tbl[i].exp_ovf4);
      chk("tbl_idle_mode", int'(mode), 0);
      chk("tbl_idle_stress", int'(stress), 15);
    end

    // out-of-range channel on a 3-channel instance
    d = n_done3; seen = 0;
    @(posedge clk); #1;
    start3 = 1'b1; ch_sel = 2'd3; window = 16'd5;
    @(posedge clk); #1;
    start3 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (busy3 === 1'b1) seen = 1;
      @(posedge clk); #1;
    end
    chk("oor_busy", seen, 0);
    chk("oor_done", n_done3 - d, 0);
    start3 = 1'b1; ch_sel = 2'd1; window = 16'd0;
    seen = -1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      start3 = 1'b0;
      if (done3 === 1'b1 && seen < 0) seen = k;
    end
    chk("n3_win0_latency", seen, S + 1);
    chk("n3_win0_count", int'(count3), 0);

    // second start mid-measure is dropped
    run(1, 30, 4, 0, 1'b1);

    // stress toggled while measuring channel 0
    stress_en = 1'b1;
    run(0, 40, 4, 2, 1'b0);
    chk("toggle_count", int'(count), 10);
    chk("toggle_idle_stress", int'(stress), 0);
    stress_en = 1'b1;

    // reset in the middle of the window
    @(posedge clk); #1;
    start = 1'b1; ch_sel = 2'd2; window = 16'd100;
    for (int c = 0; c < S + 50; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      ro_in[2] = bit'((c / 2) % 2);
    end
    rst_n = 1'b0;
    d = n_done;
    @(posedge clk); #1;
    chk("midrst_mode", int'(mode), 0);
    chk("midrst_stress", int'(stress), 0);
    chk("midrst_busy", int'(busy), 0);
    rst_n = 1'b1;
    for (int c = 0; c < 120; c++) begin
      @(posedge clk); #1;
      ro_in[2] = bit'((c / 2) % 2);
    end
    chk("midrst_no_done", n_done - d, 0);
    chk("midrst_count", int'(count), 0);
    chk("midrst_ovf", int'(ovf), 0);
    run(2, 100, 4, 0, 1'b0);
    chk("after_rst_count", int'(count), 25);

    // randomized windows, waveforms and stress activity
    for (int r = 0; r < 25; r++)
      run($urandom_range(3), $urandom_range(40), 0, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
